// File: rtl/transition_logger.sv
// Timestamps every value change on a single observed net and queues {time, value}
// events in a FIFO that a valid/ready consumer drains.
module transition_logger #(
  parameter int unsigned TS_WIDTH = 16,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sig_in,
  input  logic                    clr_ovf,
  input  logic                    ev_ready,
  output logic                    ev_valid,
  output logic [TS_WIDTH-1:0]     ev_time,
  output logic                    ev_value,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [TS_WIDTH-1:0] ts_q;
  logic                prev_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [TS_WIDTH:0]   mem_q [DEPTH];
  logic [TS_WIDTH:0]   head;

  logic detect, pop, full, push, drop;

  always_comb begin
    detect = en && (sig_in != prev_q);
    pop    = (count_q != '0) && ev_ready;
    full   = (count_q == FullCount);
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    push   = detect && (!full || pop);
    drop   = detect && full && !pop;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (en) begin
        ts_q   <= ts_q + 1'b1;
        prev_q <= sig_in;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_q, sig_in};
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    ev_valid = (count_q != '0);
    ev_time  = ev_valid ? head[TS_WIDTH:1] : '0;
    ev_value = ev_valid & head[0];
    count    = count_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_transition_logger.sv
// Directed bench for transition_logger: expected events go into a scoreboard queue
// and a negedge monitor compares every popped event against it.
module tb_transition_logger;

  logic        clk = 1'b0;
  logic        rst, en, sig_in, clr_ovf, ev_ready;
  logic        ev_valid, ev_value, overflow;
  logic [15:0] ev_time;
  logic [3:0]  count;

  logic        rst4, en4, sig4, ready4, clr4;
  logic        valid4, value4, ovf4;
  logic [3:0]  time4;
  logic [3:0]  count4;

  typedef struct packed {logic [15:0] t; logic v;} ev_t;
  ev_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  transition_logger #(.TS_WIDTH(16), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .clr_ovf(clr_ovf),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_time(ev_time), .ev_value(ev_value),
    .count(count), .overflow(overflow)
  );

  transition_logger #(.TS_WIDTH(4), .DEPTH(8)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en4), .sig_in(sig4), .clr_ovf(clr4),
    .ev_ready(ready4), .ev_valid(valid4), .ev_time(time4), .ev_value(value4),
    .count(count4), .overflow(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; sig_in = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    step(1);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic expect_ev(input int t, input logic v);
    ev_t e;
    e.t = 16'(t);
    e.v = v;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: a pop happens at the next edge whenever valid && ready.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got time %0d value %0d, expected none",
                   ev_time, ev_value);
        end else begin
          e = exp_q.pop_front();
          check("ev_time", 32'(ev_time), 32'(e.t));
          check("ev_value", 32'(ev_value), 32'(e.v));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    rst4 = 1'b1; en4 = 1'b0; sig4 = 1'b0; ready4 = 1'b0; clr4 = 1'b0;

    // 1: quiet for ts 0..9, rise at ts=10
    do_reset();
    check("reset_count", 32'(count), 0);
    check("reset_overflow", 32'(overflow), 0);
    for (int i = 0; i < 10; i++) begin
      check("t1_idle_valid", 32'(ev_valid), 0);
      step(1);
    end
    sig_in = 1'b1;
    expect_ev(10, 1'b1);
    step(1);
    check("t1_valid", 32'(ev_valid), 1);
    check("t1_time", 32'(ev_time), 10);
    check("t1_value", 32'(ev_value), 1);
    check("t1_count", 32'(count), 1);
    ev_ready = 1'b1;
    step(1);
    check("t1_drained", 32'(count), 0);

    // 2: fill with toggles from ts=0, ninth event dropped
    do_reset();
    for (int i = 0; i < 9; i++) begin
      check("t2_count", 32'(count), 32'(i));
      check("t2_ovf_clear", 32'(overflow), 0);
      sig_in = (i % 2 == 0);
      if (i < 8) expect_ev(i, (i % 2 == 0));
      step(1);
    end
    check("t2_full_count", 32'(count), 8);
    check("t2_overflow", 32'(overflow), 1);

    // 3: clear overflow, then push into a full FIFO while popping
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("t3_ovf_cleared", 32'(overflow), 0);
    sig_in = 1'b0;
    ev_ready = 1'b1;
    expect_ev(10, 1'b0);
    step(1);
    check("t3_count_full", 32'(count), 8);
    check("t3_overflow", 32'(overflow), 0);
    for (int k = 0; k < 20 && ev_valid; k++) step(1);
    check("t3_drain_done", 32'(ev_valid), 0);
    check("t3_empty_time", 32'(ev_time), 0);
    check("t3_empty_value", 32'(ev_value), 0);
    check("t3_pending", 32'(exp_q.size()), 0);

    // 4: disabled at ts=20 while sig_in wiggles; one event on re-enable
    do_reset();
    ev_ready = 1'b1;
    step(20);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = (i % 2 == 0);
      step(1);
      check("t4_no_event", 32'(count), 0);
    end
    en = 1'b1;
    sig_in = 1'b1;
    expect_ev(20, 1'b1);
    step(1);
    check("t4_valid", 32'(ev_valid), 1);
    check("t4_time", 32'(ev_time), 20);
    step(1);
    check("t4_single", 32'(count), 0);
    step(2);
    check("t4_still_single", 32'(count), 0);

    // 6: drop coinciding with clr_ovf, drain to 5, then reset mid-operation
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sig_in = (i % 2 == 0);
      clr_ovf = (i == 8);
      if (i < 8) expect_ev(i, (i % 2 == 0));
      step(1);
    end
    clr_ovf = 1'b0;
    check("t6_set_wins", 32'(overflow), 1);
    ev_ready = 1'b1;
    step(3);
    ev_ready = 1'b0;
    check("t6_count5", 32'(count), 5);
    check("t6_ovf_held", 32'(overflow), 1);
    do_reset();
    check("t6_valid", 32'(ev_valid), 0);
    check("t6_count", 32'(count), 0);
    check("t6_overflow", 32'(overflow), 0);
    check("t6_time", 32'(ev_time), 0);
    step(3);
    sig_in = 1'b1;
    ev_ready = 1'b1;
    expect_ev(3, 1'b1);
    step(1);
    check("t6_restamp", 32'(ev_time), 3);
    step(2);
    check("t6_pending", 32'(exp_q.size()), 0);

    // 5: 4-bit timestamp wrap, changes at ts=15 and ts=0
    rst4 = 1'b1; en4 = 1'b1; sig4 = 1'b0; ready4 = 1'b1;
    step(1);
    rst4 = 1'b0;
    step(15);
    sig4 = 1'b1;
    step(1);
    check("t5_valid_a", 32'(valid4), 1);
    check("t5_time_a", 32'(time4), 15);
    check("t5_value_a", 32'(value4), 1);
    sig4 = 1'b0;
    step(1);
    check("t5_valid_b", 32'(valid4), 1);
    check("t5_time_b", 32'(time4), 0);
    check("t5_value_b", 32'(value4), 0);
    step(1);
    check("t5_empty", 32'(valid4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/transition_logger.md
Name: transition_logger

Overview:
- Downstream observer for the small gate-level test circuits; consumes a single circuit output net (e.g. F of an AND/OR test circuit).
- Timestamps every value change on that net and queues {time, new value} events in a FIFO; these are the reference event stream for the event-driven simulator.
- A valid/ready consumer drains the queue.

Parameters:
- TS_WIDTH, 16, width of free-running timestamp counter and of ev_time.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sampling enable; 0 freezes timestamp and change detection.
- sig_in  input  1  observed circuit output net.
- clr_ovf  input  1  clears sticky overflow flag.
- ev_ready  input  1  consumer accepts head event this cycle.
- ev_valid  output  1  FIFO non-empty; head event presented.
- ev_time  output  TS_WIDTH  timestamp of head event.
- ev_value  output  1  value sig_in changed to.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: at least one event dropped.

Behaviour:
- Reset: when rst=1 at a clock edge, the following are cleared: ts, prev, FIFO pointers, count, overflow. After that edge, ev_valid=0, ev_time=0, ev_value=0, count=0, overflow=0. Reset has priority over every other input. Reset mid-operation discards all queued events.
- Timestamp ts:
  - Increments by 1 each cycle with en=1 and holds when en=0.
  - Wraps from 2^TS_WIDTH-1 to 0 with no marker or flag.
- Change detect:
  - Event in a cycle when en=1 and sig_in != prev.
  - prev <= sig_in every cycle with en=1, so each sustained change yields exactly one event.
  - prev resets to 0, so sig_in=1 in the first enabled cycle after reset logs an event at ts=0.
- Event payload: {ts value in the detect cycle, sig_in}.
- Push timing: the event is written at the end of the detect cycle. ev_valid rises the next cycle (latency 1), with no bypass.
- Pop: occurs when ev_valid && ev_ready. The head advances at that edge, and the next entry (if any) is presented the following cycle.
- Output when empty: ev_valid=0, ev_time=0, ev_value=0.
- Occupancy: count is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (count=DEPTH):
  - Push without a same-cycle pop: event dropped, overflow set, contents and count unchanged.
  - Push with a same-cycle pop: event accepted, count stays DEPTH, overflow not set.
- Empty with push: no pop is possible that cycle; count becomes 1 next cycle.
- Pointers: wrap modulo DEPTH; count distinguishes full from empty.
- overflow:
  - Sticky until clr_ovf=1 or rst.
  - If a drop and clr_ovf coincide, set wins (overflow=1 next cycle).
- en=0:
  - No events are generated, and sig_in changes are ignored.
  - FIFO reads continue normally.
  - On re-enable, sig_in is compared against the frozen prev, giving at most one event, stamped with the frozen ts.
- Ordering: events are delivered strictly in detection order. Timestamps are non-decreasing except across a wrap.

Test Plan:
1. Reset, en=1, sig_in=0 for 10 cycles, then sig_in=1 from the cycle with ts=10 -> ev_valid=0 throughout the first 10 cycles; next cycle ev_valid=1, ev_time=10, ev_value=1, count=1.
2. ev_ready=0, sig_in toggles every cycle from ts=0 for 9 cycles -> count=8 after 8 events and overflow=1 after the 9th; then ev_ready=1 drains 8 events with ev_time 0..7 and ev_value alternating 1,0,1,...; ev_valid=0 afterwards.
3. FIFO full (count=8), sig_in toggles while ev_ready=1 -> count stays 8, overflow stays 0, and the new event appears last in drain order.
4. en=0 for 5 cycles while sig_in toggles 0->1->0->1 with frozen ts=20 and prev=0 -> no events, ts holds 20; re-enable with sig_in=1 -> exactly one event {20,1}.
5. TS_WIDTH=4: sig_in changes at ts=15 and again at ts=0 the next cycle -> events ev_time 15 then 0.
6. Reset mid-operation with count=5 and overflow=1, rst asserted one cycle -> next cycle ev_valid=0, count=0, overflow=0, ev_time=0; the first subsequent change is stamped from ts=0. Also drive clr_ovf=1 during a drop -> overflow remains 1.
